fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of Ctrl. Holds the program counter (PC),

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, synchronous ROM fetch, redirect squash, run/done control and cycle counting
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W = 16,
  parameter int START_ADDR = 0,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  output logic [PC_W-1:0]    Rom_Addr,
  input  logic [INSTR_W-1:0] Rom_Rdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic [PC_W-1:0]    Instr_PC,
  output logic               Instr_Valid,
  input  logic               PC_Jmp_Flag,
  input  logic               PC_Beq_Flag,
  input  logic [PC_W-1:0]    Lut_Target,
  input  logic               Ack,
  output logic               Done,
  output logic [CNT_W-1:0]   Cycle_Count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  state_t state_q, state_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d, instr_pc_q, instr_pc_d;
  logic valid_q, valid_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    f_pc_d = f_pc_q;
    instr_pc_d = instr_pc_q;
    valid_d = valid_q;
    done_d = done_q;
    cnt_d = cnt_q;
    if (state_q != RUN && Start) begin
      state_d = RUN;
      f_pc_d = START + PC_W'(1);
      instr_pc_d = START;
      valid_d = 1'b1;
      done_d = 1'b0;
      cnt_d = CNT_W'(1);
    end else if (state_q == RUN) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      if (valid_q && Ack) begin
        state_d = DONE;
        done_d = 1'b1;
        valid_d = 1'b0;
        f_pc_d = START;
      end else if (valid_q && (PC_Jmp_Flag || PC_Beq_Flag)) begin
        f_pc_d = PC_Jmp_Flag ? Lut_Target : instr_pc_q + Lut_Target;
        valid_d = 1'b0;
      end else begin
        instr_pc_d = f_pc_q;
        f_pc_d = f_pc_q + PC_W'(1);
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      f_pc_q <= START;
      instr_pc_q <= START;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      f_pc_q <= f_pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q <= valid_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
  assign Rom_Addr = f_pc_q;
  assign Instr_PC = instr_pc_q;
  assign Instr_Valid = valid_q;
  assign Done = done_q;
  assign Cycle_Count = cnt_q;
  assign Instruction = valid_q ? Rom_Rdata : NOP_WORD;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks against a 1-cycle ROM holding ROM[i]=i[8:0]
module tb_fetch_unit;
  logic Clk = 0, Reset_n = 0, Start = 0, Ack = 0, jmp = 0, beq = 0;
  logic [9:0] Rom_Addr, Instr_PC, lut = 0;
  logic [8:0] rom_rdata, Instruction;
  logic Instr_Valid, Done;
  logic [15:0] Cycle_Count, exp_cnt = 0;
  logic run_m = 0;
  int checks = 0, failures = 0;
  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Rom_Addr(Rom_Addr), .Rom_Rdata(rom_rdata),
    .Instruction(Instruction), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid),
    .PC_Jmp_Flag(jmp), .PC_Beq_Flag(beq), .Lut_Target(lut), .Ack(Ack), .Done(Done),
    .Cycle_Count(Cycle_Count)
  );
  always #5 Clk = ~Clk;
  always_ff @(posedge Clk) rom_rdata <= Rom_Addr[8:0];
  task automatic tick;
    @(posedge Clk);
    #1;
    if (run_m && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask
  task automatic go;
    Start = 1;
    @(posedge Clk);
    #1;
    Start = 0;
    exp_cnt = 16'd1;
    run_m = 1;
  endtask
  task automatic redirect(input logic j, input logic b, input logic [9:0] t);
    jmp = j;
    beq = b;
    lut = t;
    tick;
    jmp = 0;
    beq = 0;
  endtask
  task automatic test_reset;
    Reset_n = 0;
    tick;
    tick;
    Reset_n = 1;
    checks += 5;
    if (Instr_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", Instr_Valid); end
    if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", Done); end
    if (Cycle_Count !== 16'd0) begin failures++; $display("FAIL reset_cnt got %h exp 0", Cycle_Count); end
    if (Instr_PC !== 10'd0 || Rom_Addr !== 10'd0) begin failures++; $display("FAIL reset_pc got %h/%h exp 0/0", Instr_PC, Rom_Addr); end
    if (Instruction !== 9'h000) begin failures++; $display("FAIL reset_instr got %h exp 000", Instruction); end
  endtask
  task automatic test_sequential;
    go;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick;
      checks += 3;
      if (Instr_PC !== 10'(k) || Instr_Valid !== 1'b1) begin failures++; $display("FAIL seq_pc%0d got %h/%b exp %h/1", k, Instr_PC, Instr_Valid, 10'(k)); end
      if (Instruction !== 9'(k)) begin failures++; $display("FAIL seq_instr%0d got %h exp %h", k, Instruction, 9'(k)); end
      if (Cycle_Count !== 16'(k + 1)) begin failures++; $display("FAIL seq_cnt%0d got %0d exp %0d", k, Cycle_Count, k + 1); end
    end
  endtask
  task automatic test_jump;
    redirect(1, 0, 10'h040);
    checks += 5;
    if (Instr_Valid !== 1'b0 || Instruction !== 9'h000) begin failures++; $display("FAIL jmp_bubble got %b/%h exp 0/000", Instr_Valid, Instruction); end
    if (Cycle_Count !== 16'd5) begin failures++; $display("FAIL jmp_bubble_cnt got %0d exp 5", Cycle_Count); end
    tick;
    if (Instr_PC !== 10'h040 || Instr_Valid !== 1'b1) begin failures++; $display("FAIL jmp_target got %h/%b exp 040/1", Instr_PC, Instr_Valid); end
    if (Instruction !== 9'h040) begin failures++; $display("FAIL jmp_instr got %h exp 040", Instruction); end
    tick;
    if (Instr_PC !== 10'h041) begin failures++; $display("FAIL jmp_next got %h exp 041", Instr_PC); end
  endtask
  task automatic test_branch;
    redirect(1, 0, 10'h010);
    tick;
    redirect(0, 1, 10'h3FC);
    checks += 6;
    if (Instr_Valid !== 1'b0) begin failures++; $display("FAIL beq_bubble got %b exp 0", Instr_Valid); end
    tick;
    if (Instr_PC !== 10'h00C || Instruction !== 9'h00C) begin failures++; $display("FAIL beq_back got %h/%h exp 00C/00C", Instr_PC, Instruction); end
    redirect(1, 0, 10'h3FE);
    tick;
    redirect(0, 1, 10'h005);
    tick;
    if (Instr_PC !== 10'h003 || Instr_Valid !== 1'b1) begin failures++; $display("FAIL beq_wrap got %h/%b exp 003/1", Instr_PC, Instr_Valid); end
    redirect(1, 1, 10'h100);
    tick;
    if (Instr_PC !== 10'h100) begin failures++; $display("FAIL jmp_beats_beq got %h exp 100", Instr_PC); end
    redirect(1, 0, 10'h3FF);
    tick;
    if (Instr_PC !== 10'h3FF) begin failures++; $display("FAIL top_pc got %h exp 3FF", Instr_PC); end
    tick;
    if (Instr_PC !== 10'h000 || Instr_Valid !== 1'b1) begin failures++; $display("FAIL seq_wrap got %h/%b exp 000/1", Instr_PC, Instr_Valid); end
  endtask
  task automatic test_start_ignored;
    Start = 1;
    tick;
    Start = 0;
    checks += 2;
    if (Instr_PC !== 10'h001 || Instr_Valid !== 1'b1 || Done !== 1'b0) begin failures++; $display("FAIL run_start got %h/%b/%b exp 001/1/0", Instr_PC, Instr_Valid, Done); end
    if (Cycle_Count !== exp_cnt) begin failures++; $display("FAIL run_start_cnt got %0d exp %0d", Cycle_Count, exp_cnt); end
  endtask
  task automatic test_bubble_ack;
    redirect(1, 0, 10'h01F);
    jmp = 1;
    beq = 1;
    lut = 10'h200;
    tick;
    jmp = 0;
    beq = 0;
    checks += 7;
    if (Instr_PC !== 10'h01F || Instr_Valid !== 1'b1) begin failures++; $display("FAIL bubble_flags got %h/%b exp 01F/1", Instr_PC, Instr_Valid); end
    tick;
    if (Instr_PC !== 10'h020) begin failures++; $display("FAIL bubble_seq got %h exp 020", Instr_PC); end
    Ack = 1;
    jmp = 1;
    lut = 10'h200;
    tick;
    Ack = 0;
    jmp = 0;
    run_m = 0;
    if (Done !== 1'b1 || Instr_Valid !== 1'b0) begin failures++; $display("FAIL ack_done got %b/%b exp 1/0", Done, Instr_Valid); end
    if (Rom_Addr !== 10'h000 || Instruction !== 9'h000) begin failures++; $display("FAIL ack_noredirect got %h/%h exp 000/000", Rom_Addr, Instruction); end
    if (Cycle_Count !== exp_cnt) begin failures++; $display("FAIL ack_cnt got %0d exp %0d", Cycle_Count, exp_cnt); end
    tick;
    tick;
    if (Done !== 1'b1 || Instr_Valid !== 1'b0) begin failures++; $display("FAIL done_hold got %b/%b exp 1/0", Done, Instr_Valid); end
    if (Cycle_Count !== exp_cnt) begin failures++; $display("FAIL done_cnt_frozen got %0d exp %0d", Cycle_Count, exp_cnt); end
  endtask
  task automatic test_restart_saturate;
    go;
    checks += 6;
    if (Done !== 1'b0 || Instr_PC !== 10'h000 || Instr_Valid !== 1'b1) begin failures++; $display("FAIL restart got %b/%h/%b exp 0/000/1", Done, Instr_PC, Instr_Valid); end
    if (Cycle_Count !== 16'd1) begin failures++; $display("FAIL restart_cnt got %0d exp 1", Cycle_Count); end
    tick;
    if (Instr_PC !== 10'h001 || Cycle_Count !== 16'd2) begin failures++; $display("FAIL restart_next got %h/%0d exp 001/2", Instr_PC, Cycle_Count); end
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFE; i++) tick;
    if (Cycle_Count !== 16'hFFFE) begin failures++; $display("FAIL cnt_fffe got %h exp FFFE", Cycle_Count); end
    tick;
    if (Cycle_Count !== 16'hFFFF) begin failures++; $display("FAIL cnt_ffff got %h exp FFFF", Cycle_Count); end
    tick;
    if (Cycle_Count !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat got %h exp FFFF", Cycle_Count); end
  endtask
  task automatic test_reset_mid;
    redirect(1, 0, 10'h080);
    Reset_n = 0;
    tick;
    Reset_n = 1;
    run_m = 0;
    exp_cnt = 0;
    checks += 6;
    if (Instr_Valid !== 1'b0 || Done !== 1'b0 || Cycle_Count !== 16'd0) begin failures++; $display("FAIL rst_mid got %b/%b/%h exp 0/0/0", Instr_Valid, Done, Cycle_Count); end
    if (Instr_PC !== 10'h000 || Rom_Addr !== 10'h000) begin failures++; $display("FAIL rst_mid_pc got %h/%h exp 000/000", Instr_PC, Rom_Addr); end
    tick;
    if (Instr_Valid !== 1'b0 || Rom_Addr !== 10'h000 || Cycle_Count !== 16'd0) begin failures++; $display("FAIL rst_idle got %b/%h/%h exp 0/000/0", Instr_Valid, Rom_Addr, Cycle_Count); end
    go;
    if (Instr_PC !== 10'h000 || Instr_Valid !== 1'b1 || Instruction !== 9'h000) begin failures++; $display("FAIL rst_start got %h/%b/%h exp 000/1/000", Instr_PC, Instr_Valid, Instruction); end
    tick;
    if (Instr_PC !== 10'h001 || Instr_Valid !== 1'b1) begin failures++; $display("FAIL rst_no_squash got %h/%b exp 001/1", Instr_PC, Instr_Valid); end
    if (Cycle_Count !== 16'd2) begin failures++; $display("FAIL rst_cnt got %0d exp 2", Cycle_Count); end
  endtask
  initial begin
    test_reset;
    test_sequential;
    test_jump;
    test_branch;
    test_start_ignored;
    test_bubble_ack;
    test_restart_saturate;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
